// File: rtl/ps2_pkg.sv
// Shared scancode constants, receiver state encoding and the direction-key test
// for the PS/2 direction receiver.
package ps2_pkg;

  localparam logic [7:0] KEY_W    = 8'h1D;
  localparam logic [7:0] KEY_S    = 8'h1B;
  localparam logic [7:0] KEY_A    = 8'h1C;
  localparam logic [7:0] KEY_D    = 8'h23;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] DIR_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic is_direction(input logic [7:0] b);
    return (b == KEY_W) || (b == KEY_S) || (b == KEY_A) || (b == KEY_D);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce filter for one raw PS/2 line;
// the filtered level idles high and flips only after FILTER_LEN equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    // Count consecutive samples that disagree with the accepted level.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = level_q;

endmodule

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard frame receiver that holds the current W/S/A/D make code in
// letra and clears it when the matching break sequence arrives.
module ps2_direction_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] letra,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_f, data_f, fall;
  logic          clk_prev_q, clk_prev_d;
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    scancode_q, scancode_d;
  logic [7:0]    letra_q, letra_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          timeout, frame_ok, frame_bad;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (ps2_clk),
    .line_o (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (ps2_data),
    .line_o (data_f)
  );

  assign clk_prev_d = clk_f;
  assign fall       = clk_prev_q & ~clk_f;

  // A stalled frame is abandoned even if a fall lands in the same cycle.
  assign timeout   = (state_q != IDLE) && (tmo_q == TMO_MAX);
  assign frame_ok  = !timeout && fall && (state_q == STOP) && data_f && (^{shift_q, par_q});
  assign frame_bad = timeout ||
                     (fall && (state_q == STOP) && !frame_ok) ||
                     (fall && (state_q == IDLE) && data_f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_f) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (fall && !timeout) begin
      case (state_q)
        IDLE:    bit_cnt_d = '0;
        DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY:  par_d = data_f;
        default: ;
      endcase
    end
    tmo_d = tmo_q;
    if (fall)                                      tmo_d = '0;
    else if ((state_q != IDLE) && (tmo_q != TMO_MAX)) tmo_d = tmo_q + TW'(1);
  end

  always_comb begin
    code_valid_d = frame_ok;
    frame_err_d  = frame_bad;
    scancode_d   = scancode_q;
    letra_d      = letra_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    if (frame_ok) begin
      scancode_d = shift_q;
      if (shift_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        // Extended sequences, including E0 F0 xx, never touch letra.
        if (brk_q && !ext_q && (shift_q == letra_q)) letra_d = DIR_NONE;
        else if (!brk_q && !ext_q && is_direction(shift_q)) letra_d = shift_q;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scancode_q   <= '0;
      letra_q      <= DIR_NONE;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
    end else begin
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      scancode_q   <= scancode_d;
      letra_q      <= letra_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
    end
  end

  assign letra      = letra_q;
  assign scancode   = scancode_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Bench for ps2_direction_rx: table of PS/2 frames with expected pulses and held
// codes, plus reset, bad-start, timeout and glitch sequences; scoreboard checked on each pulse.
module tb_ps2_direction_rx;

  localparam int HALF = 20;
  localparam int TMO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] letra, scancode;
  logic       code_valid, frame_err;

  ps2_direction_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .letra      (letra),
    .scancode   (scancode),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] sc;
    logic [7:0] le;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    logic       err;
    logic [7:0] sc;
    logic [7:0] le;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[17];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] cur_sc, cur_le;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (code_valid && frame_err) check("pulses_exclusive", 1, 0);
      if (code_valid || frame_err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {code_valid, frame_err}, 0);
        end else begin
          mon_e = q.pop_front();
          check("pulse_is_err", frame_err, mon_e.err);
          check("scancode", scancode, mon_e.sc);
          check("letra", letra, mon_e.le);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int stall_after, input int rst_at, input bit glitch);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      if (i == rst_at) begin
        wait_clks(3);
        rst_n = 1'b0;
        wait_clks(3);
        check("rst_mid_letra", letra, 8'h00);
        check("rst_mid_scancode", scancode, 8'h00);
        check("rst_mid_pulses", {code_valid, frame_err}, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(40);
        return;
      end
      wait_clks(HALF);
      ps2_clk = 1'b1;
      if (glitch && i < 10) begin
        wait_clks(5);
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
      end
      if (i == stall_after) begin
        ps2_data = 1'b1;
        return;
      end
    end
    ps2_data = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    check("expected_pulse_seen", q.size(), 0);
    q.delete();
  endtask

  initial begin
    vecs[0]  = '{8'h1D, 0, 0, 1'b0, 8'h1D, 8'h1D};
    vecs[1]  = '{8'hF0, 0, 0, 1'b0, 8'hF0, 8'h1D};
    vecs[2]  = '{8'h1D, 0, 0, 1'b0, 8'h1D, 8'h00};
    vecs[3]  = '{8'h23, 0, 0, 1'b0, 8'h23, 8'h23};
    vecs[4]  = '{8'hF0, 0, 0, 1'b0, 8'hF0, 8'h23};
    vecs[5]  = '{8'h1B, 0, 0, 1'b0, 8'h1B, 8'h23};
    vecs[6]  = '{8'h1C, 1, 0, 1'b1, 8'h1B, 8'h23};
    vecs[7]  = '{8'h1C, 0, 1, 1'b1, 8'h1B, 8'h23};
    vecs[8]  = '{8'h2B, 0, 0, 1'b0, 8'h2B, 8'h23};
    vecs[9]  = '{8'hE0, 0, 0, 1'b0, 8'hE0, 8'h23};
    vecs[10] = '{8'h1D, 0, 0, 1'b0, 8'h1D, 8'h23};
    vecs[11] = '{8'h1C, 0, 0, 1'b0, 8'h1C, 8'h1C};
    vecs[12] = '{8'hE0, 0, 0, 1'b0, 8'hE0, 8'h1C};
    vecs[13] = '{8'hF0, 0, 0, 1'b0, 8'hF0, 8'h1C};
    vecs[14] = '{8'h1C, 0, 0, 1'b0, 8'h1C, 8'h1C};
    vecs[15] = '{8'h1B, 0, 0, 1'b0, 8'h1B, 8'h1B};
    vecs[16] = '{8'h23, 0, 0, 1'b0, 8'h23, 8'h23};

    // Traffic on the lines while held in reset.
    for (int i = 0; i < 4; i++) begin
      ps2_data = i[0];
      wait_clks(8);
      ps2_clk = 1'b0;
      wait_clks(8);
      ps2_clk = 1'b1;
    end
    check("reset_letra", letra, 8'h00);
    check("reset_scancode", scancode, 8'h00);
    check("reset_pulses", {code_valid, frame_err}, 0);
    ps2_data = 1'b1;
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(20);

    for (int v = 0; v < 17; v++) begin
      q.push_back('{vecs[v].err, vecs[v].sc, vecs[v].le});
      send_frame(vecs[v].b, vecs[v].bad_par, vecs[v].bad_stop, -1, -1, 1'b0);
      drain(200);
      cur_sc = vecs[v].sc;
      cur_le = vecs[v].le;
    end

    // Start bit sampled high.
    q.push_back('{1'b1, cur_sc, cur_le});
    ps2_data = 1'b1;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
    drain(200);

    // Clock stalls after the 4th data bit.
    q.push_back('{1'b1, cur_sc, cur_le});
    send_frame(8'h1B, 0, 0, 4, -1, 1'b0);
    drain(TMO + 200);
    wait_clks(50);
    check("timeout_single_pulse", q.size(), 0);

    q.push_back('{1'b0, 8'h1B, 8'h1B});
    send_frame(8'h1B, 0, 0, -1, -1, 1'b0);
    drain(200);

    // Reset lands during the parity bit.
    send_frame(8'h23, 0, 0, -1, 9, 1'b0);
    check("post_reset_letra", letra, 8'h00);
    check("post_reset_scancode", scancode, 8'h00);
    q.push_back('{1'b0, 8'h1C, 8'h1C});
    send_frame(8'h1C, 0, 0, -1, -1, 1'b0);
    drain(200);

    // Short glitches on ps2_clk must not add bits.
    q.push_back('{1'b0, 8'h23, 8'h23});
    send_frame(8'h23, 0, 0, -1, -1, 1'b1);
    drain(200);
    wait_clks(50);
    check("final_letra", letra, 8'h23);
    check("final_scancode", scancode, 8'h23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_direction_rx.md
# ps2_direction_rx

Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data lines and turns them into the held 8-bit direction code `letra` consumed by the Pac-Man sprite stage. Only W/S/A/D make codes update `letra`. A matching break sequence clears it to 0x00. Sits directly upstream of the sprite renderer, between the board PS/2 pins and the game/sprite logic.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized samples required before a PS/2 line level is accepted.
- TIMEOUT_CYCLES, 50000: clk cycles without a falling ps2_clk edge mid-frame before the frame is abandoned (1 ms at 50 MHz).
- clk  in  1  system clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the pin; asynchronous.
- ps2_data  in  1  raw PS/2 data from the pin; asynchronous.
- letra  out  8  held direction scancode: 0x1D, 0x1B, 0x1C, 0x23 or 0x00 (none).
- scancode  out  8  last correctly received byte, any key, including 0xF0 and 0xE0.
- code_valid  out  1  one-cycle pulse when scancode updates.
- frame_err  out  1  one-cycle pulse on a parity, start or stop error, or on timeout.

## Operation
- Line conditioning:
  - Each line passes through a 2-FF synchronizer, then a filter.
  - The filtered level changes only after FILTER_LEN equal consecutive samples.
  - Filtered reset level is 1.
- Falling-edge detect on filtered ps2_clk gives `fall`, a one-cycle pulse. Filtered data is sampled on `fall`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 go to DATA, bit counter=0. On `fall` with data=1, pulse frame_err and stay in IDLE.
  - DATA: shift data in LSB-first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: require stop=1 and odd parity over data+parity.
    - On pass: update scancode and pulse code_valid.
    - On fail: pulse frame_err.
    - Either way, return to IDLE.
- Timeout: a counter clears on every `fall` and counts in DATA, PARITY and STOP. Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err. The counter saturates and never wraps.
- Decode, applied to accepted bytes only:
  - 0xF0 sets break_pending.
  - 0xE0 sets ext_pending.
  - For any other byte B:
    - If break_pending is set and B==letra, letra becomes 0x00.
    - Otherwise, if neither pending flag is set and B ∈ {1D,1B,1C,23}, letra becomes B.
    - Both pending flags clear after B.
  - Non-direction bytes leave letra unchanged.
  - Extended codes (E0-prefixed, including E0 F0 xx) never change letra.
  - A new direction make code overwrites letra immediately; no release is needed.
- Errored frames do not touch the pending flags, letra or scancode.
- Reset values: letra=0x00, scancode=0x00, code_valid=0, frame_err=0, FSM in IDLE, both pending flags=0, counters=0.
- Reset mid-frame discards the partial byte; the next start bit begins a fresh frame.

## Timing
- From a raw ps2_clk fall to `fall`: 2 sync cycles plus FILTER_LEN cycles, then 1 edge-detect cycle.
- code_valid and the scancode update occur in the cycle after the `fall` for the stop bit.
- letra updates in the same cycle as code_valid, so all three are registered together.
- Pulses are exactly one cycle wide.
- code_valid and frame_err are never high together.
- Back-to-back frames are accepted with no dead time: a start bit on the first `fall` after STOP is honoured.
- PS/2 frequency is 10–16.7 kHz, which is far below clk; at most one `fall` occurs per FILTER_LEN+1 cycles.

## Structure
- Package ps2_pkg holds:
  - Constants KEY_W=8'h1D, KEY_S=8'h1B, KEY_A=8'h1C, KEY_D=8'h23, SC_BREAK=8'hF0, SC_EXT=8'hE0, DIR_NONE=8'h00.
  - The rx_state_t enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_line_filter: 2-FF sync plus FILTER_LEN debounce for one line, instantiated twice.
- Frame FSM, timeout counter and decode stay in the top module.

## Test plan
- Reset with rst_n=0 mid-stream → letra=00, scancode=00, no pulses. Release, send 0x1D with good parity → code_valid pulses once, scancode=1D, letra=1D.
- Send 0x1D, then F0, then 1D → three code_valid pulses, letra ends at 00. Send 0x23, then F0 1B → letra stays 23.
- Send 0x1C with the parity bit flipped → frame_err pulses, code_valid stays 0, letra and scancode unchanged. Send a frame with stop=0 → same response.
- Send 0x2B (non-direction) → scancode=2B, letra unchanged. Send E0 1D → letra unchanged, scancode=1D.
- Stop ps2_clk after the 4th data bit for TIMEOUT_CYCLES cycles → frame_err pulses once. A following valid 0x1B frame → letra=1B.
- Assert rst_n low during the parity bit of 0x23, release, then send 0x1C → letra=1C and no frame_err. Inject glitches on ps2_clk shorter than FILTER_LEN → no extra bits are captured.
